// File: rtl/gate_tt_checker.sv
// Truth-table sequencer for two-input gates: drives all four {in1,in2} vectors, samples the gate output, and reports mismatches.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_gate_sel;
  logic [1:0] r_v;
  logic [3:0] r_cnt;
  logic       r_in1;
  logic       r_in2;
  logic [2:0] r_err_cnt;
  logic [3:0] r_fail_vec;

  state_t     w_state;
  logic [2:0] w_gate_sel;
  logic [1:0] w_v;
  logic [3:0] w_cnt;
  logic       w_in1;
  logic       w_in2;
  logic [2:0] w_err_cnt;
  logic [3:0] w_fail_vec;
  logic       w_exp;
  logic       w_mismatch;
  logic       w_stop;

  function automatic logic gate_model(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  assign w_exp      = gate_model(r_gate_sel, r_in1, r_in2);
  assign w_mismatch = (dut_out != w_exp);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state    = r_state;
    w_gate_sel = r_gate_sel;
    w_v        = r_v;
    w_cnt      = r_cnt;
    w_in1      = r_in1;
    w_in2      = r_in2;
    w_err_cnt  = r_err_cnt;
    w_fail_vec = r_fail_vec;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_gate_sel = gate_sel;
          w_err_cnt  = '0;
          w_fail_vec = '0;
          w_v        = '0;
          w_in1      = 1'b0;
          w_in2      = 1'b0;
          w_cnt      = CNT_LOAD;
          w_state    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state = S_SAMPLE;
        else             w_cnt   = r_cnt - 4'd1;
      end
      S_SAMPLE: begin
        if (w_mismatch) begin
          w_fail_vec[r_v] = 1'b1;
          w_err_cnt       = r_err_cnt + 3'd1;
        end
        if (r_v == 2'd3 || w_stop) begin
          w_in1   = 1'b0;
          w_in2   = 1'b0;
          w_state = S_DONE;
        end else begin
          w_v          = r_v + 2'd1;
          {w_in1, w_in2} = r_v + 2'd1;
          w_cnt        = CNT_LOAD;
          w_state      = S_SETTLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gate_sel <= '0;
      r_v        <= '0;
      r_cnt      <= '0;
      r_in1      <= 1'b0;
      r_in2      <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_vec <= '0;
    end else begin
      r_state    <= w_state;
      r_gate_sel <= w_gate_sel;
      r_v        <= w_v;
      r_cnt      <= w_cnt;
      r_in1      <= w_in1;
      r_in2      <= w_in2;
      r_err_cnt  <= w_err_cnt;
      r_fail_vec <= w_fail_vec;
    end
  end

  assign in1      = r_in1;
  assign in2      = r_in2;
  assign busy     = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done     = (r_state == S_DONE);
  assign pass     = (r_state == S_DONE) && (r_err_cnt == '0);
  assign err_cnt  = r_err_cnt;
  assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: two instances (settle 2 and settle 1) driven by behavioural gate models.
module tb_gate_tt_checker;

  typedef enum logic [1:0] {M_AND, M_TIE0, M_NAND} model_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       use_b = 1'b0;
  logic [2:0] gate_sel = '0;
  logic       glitch = 1'b0;
  model_t     mode = M_AND;

  logic       a_in1, a_in2, a_busy, a_done, a_pass, a_out;
  logic [2:0] a_err;
  logic [3:0] a_fv;
  logic       b_in1, b_in2, b_busy, b_done, b_pass, b_out;
  logic [2:0] b_err;
  logic [3:0] b_fv;

  logic       o_in1, o_in2, o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [3:0] o_fv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign a_out = glitch ^ ((mode == M_AND)  ? (a_in1 & a_in2) :
                           (mode == M_NAND) ? ~(a_in1 & a_in2) : 1'b0);
  assign b_out = ~(b_in1 ^ b_in2);

  gate_tt_checker #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !use_b), .gate_sel(gate_sel),
    .dut_out(a_out), .in1(a_in1), .in2(a_in2), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_cnt(a_err), .fail_vec(a_fv)
  );

  gate_tt_checker #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && use_b), .gate_sel(gate_sel),
    .dut_out(b_out), .in1(b_in1), .in2(b_in2), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err), .fail_vec(b_fv)
  );

  assign o_in1  = use_b ? b_in1  : a_in1;
  assign o_in2  = use_b ? b_in2  : a_in2;
  assign o_busy = use_b ? b_busy : a_busy;
  assign o_done = use_b ? b_done : a_done;
  assign o_pass = use_b ? b_pass : a_pass;
  assign o_err  = use_b ? b_err  : a_err;
  assign o_fv   = use_b ? b_fv   : a_fv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run: start, walk vectors, wait for done (bounded), then check results.
  task automatic run(input string tag, input logic b, input int s, input logic [2:0] sel,
                     input int exp_cycles, input logic [2:0] exp_err, input logic [3:0] exp_fv,
                     input int pulse_at, input logic glitch_en);
    int k;
    use_b    = b;
    gate_sel = sel;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_busy"}, {30'd0, o_busy, o_done}, 32'd2);
    k = 0;
    while (!o_done && k < 60) begin
      if (k % (s + 1) == 0 && k < exp_cycles)
        check($sformatf("%s_vec%0d", tag, k / (s + 1)), {30'd0, o_in1, o_in2}, 32'(k / (s + 1)));
      glitch = glitch_en && (k % (s + 1) != s);
      start  = (k == pulse_at);
      tick();
      k++;
    end
    glitch = 1'b0;
    start  = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(exp_cycles));
    check({tag, "_err_cnt"}, {29'd0, o_err}, {29'd0, exp_err});
    check({tag, "_fail_vec"}, {28'd0, o_fv}, {28'd0, exp_fv});
    check({tag, "_pass_busy_in"}, {28'd0, o_pass, o_busy, o_in1, o_in2},
          {28'd0, (exp_err == 3'd0), 3'b000});
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_a", {20'd0, a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fv}, 32'd0);
    check("reset_b", {20'd0, b_in1, b_in2, b_busy, b_done, b_pass, b_err, b_fv}, 32'd0);
    rst_n = 1'b1;
    tick();

    mode = M_AND;
    run("and_ok", 1'b0, 2, 3'd0, 12, 3'd0, 4'b0000, -1, 1'b0);

    mode = M_TIE0;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    run("or_tie0", 1'b0, 2, 3'd1, 6, 3'd1, 4'b0010, -1, 1'b0);
`else
    run("or_tie0", 1'b0, 2, 3'd1, 12, 3'd3, 4'b1110, -1, 1'b0);
`endif

    run("xnor_ok", 1'b1, 1, 3'd5, 8, 3'd0, 4'b0000, -1, 1'b0);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    run("xor_vs_xnor", 1'b1, 1, 3'd4, 2, 3'd1, 4'b0001, -1, 1'b0);
`else
    run("xor_vs_xnor", 1'b1, 1, 3'd4, 8, 3'd4, 4'b1111, -1, 1'b0);
`endif

    mode = M_AND;
    run("and_pulse", 1'b0, 2, 3'd0, 12, 3'd0, 4'b0000, 5, 1'b0);

    use_b    = 1'b0;
    gate_sel = 3'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("mid_run_vec2", {30'd0, a_in1, a_in2}, 32'd2);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_run_reset", {20'd0, a_in1, a_in2, a_busy, a_done, a_pass, a_err, a_fv}, 32'd0);
    run("after_reset", 1'b0, 2, 3'd0, 12, 3'd0, 4'b0000, -1, 1'b0);

    mode = M_NAND;
    run("nand_glitch", 1'b0, 2, 3'd2, 12, 3'd0, 4'b0000, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Self-checking truth-table sequencer for two-input basic gates. It drives the gate under test's `in1`/`in2` through all four input combinations, waits a programmable settle time, samples the gate's `out`, and compares it against the expected value for the selected gate function. It sits on both sides of a basic-gate instance: upstream as stimulus source, downstream as response consumer. It reports a per-vector fail mask, an error count and a pass flag.

## Interface
- `SETTLE_CYCLES`, 2, cycles each vector is held before sampling; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset.
- `start`  input  1  run request; sampled only in IDLE or DONE.
- `gate_sel`  input  3  gate function, latched on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(in1), 7 NOT(in1).
- `dut_out`  input  1  output of the gate under test.
- `in1`  output  1  gate input 1, registered.
- `in2`  output  1  gate input 2, registered.
- `busy`  output  1  high in SETTLE/SAMPLE.
- `done`  output  1  high in DONE; level, held until next start.
- `pass`  output  1  high in DONE when `err_cnt`==0.
- `err_cnt`  output  3  mismatches in the current/last run (0..4).
- `fail_vec`  output  4  bit v set when vector v ({in1,in2}=v) mismatched.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset (rst_n=0 at an edge): state IDLE, all outputs 0, vector index v=0, settle counter 0. Applies mid-run; the run is abandoned and no partial results are kept.
- IDLE/DONE + start=1: latch `gate_sel`, clear `err_cnt`/`fail_vec`/`done`/`pass`, set v=0, {in1,in2}=00, load counter, go SETTLE.
- start while busy is ignored. start held high in DONE restarts on the next edge.
- SETTLE: hold vector for exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (one cycle): at its closing edge compute exp = f(gate_sel, in1, in2). If dut_out != exp: `fail_vec[v]`<=1, `err_cnt`<=err_cnt+1 (cannot exceed 4, no saturation logic needed). Then if v<3: v<=v+1, {in1,in2}<=v+1, go SETTLE; else {in1,in2}<=00, go DONE.
- DONE: `done`=1, `pass`=(err_cnt==0), results held stable, `busy`=0.
- Comparison uses the `dut_out` value present in the SAMPLE cycle only; glitches during SETTLE are ignored.

## Timing
- Per vector: SETTLE_CYCLES+1 cycles.
- start accepted at edge T0: {in1,in2}=00 and `busy`=1 visible after T0; vector v applied after edge T0+v·(S+1); `done`/`pass` high after edge T0+4·(S+1) (S=2: 12 cycles).
- `err_cnt`/`fail_vec` update at the closing edge of each SAMPLE cycle and are visible incrementally during the run.
- `done` and `busy` are never high together. `done` drops at the edge that accepts a restart.

## Configuration
- `GATE_CHK_STOP_ON_FAIL_EN` defined: the first mismatch ends the run. At the closing edge of the failing SAMPLE, the state goes directly to DONE with {in1,in2}=00. Remaining vectors are not applied, `err_cnt`=1, and `fail_vec` has exactly one bit set.
- Not defined: all four vectors are always applied, and every mismatch is counted.

## Test plan
- Correct AND model on `dut_out`, gate_sel=0, S=2, start pulse -> {in1,in2} steps 00,01,10,11 every 3 cycles; done=1 after 12 cycles; pass=1, err_cnt=0, fail_vec=0000.
- dut_out tied 0, gate_sel=1 (OR), macro off -> fail_vec=1110, err_cnt=3, pass=0. With the macro on -> DONE 6 cycles after start, fail_vec=0010, err_cnt=1.
- Correct XNOR model, gate_sel=5, S=1 -> done after 8 cycles, pass=1. Then restart with gate_sel=4 (XOR) while the XNOR model is kept -> err_cnt=4, fail_vec=1111.
- start pulsed again at cycle 5 of a run -> ignored; timing and results identical to an unpulsed run.
- rst_n=0 for one edge during vector 2 -> next cycle busy=0, done=0, in1=in2=0, err_cnt=0, fail_vec=0000. A following start runs cleanly from vector 0.
- dut_out glitched to a wrong value during SETTLE but correct in SAMPLE (NAND model, gate_sel=2) -> pass=1.
